// File: rtl/spi_mem_model_if.sv
// Purpose: SPI wire bundle plus backdoor preload port for one spi_mem_model chip select.
// Latency: none (wires only).
// Backpressure: none; SPI is master-paced and the preload port is a plain strobe.
interface spi_mem_model_if #(
  parameter int DEPTH_LOG2 = 12
);
  logic                  spi_clk;
  logic                  spi_mosi;
  logic                  spi_ce_n;
  logic                  spi_miso;
  logic                  ld_we;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [7:0]            ld_data;

  modport master (
    output spi_clk, spi_mosi, spi_ce_n, ld_we, ld_addr, ld_data,
    input  spi_miso
  );

  modport slave (
    input  spi_clk, spi_mosi, spi_ce_n, ld_we, ld_addr, ld_data,
    output spi_miso
  );
endinterface

// File: rtl/spi_mem_model.sv
// Purpose: clk-oversampled SPI mode-0 memory slave (READ 03, WRITE 02, STATUS 05; FAST READ 0B when SPI_MEM_FAST_READ_EN is defined).
// Latency: SPI edges act about 3 clk after the pin edge (2-flop sync + edge detect); backdoor write lands in the same clk.
// Backpressure: none; SPI master paces everything, backdoor ld_we is dropped while busy.
module spi_mem_model #(
  parameter int ADDR_BYTES = 3,
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_ONLY  = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_mem_model_if.slave bus,
  output logic           busy,
  output logic           cmd_err
);

  localparam int         ADDR_BITS   = ADDR_BYTES * 8;
  localparam logic [7:0] OP_READ     = 8'h03;
  localparam logic [7:0] OP_WRITE    = 8'h02;
  localparam logic [7:0] OP_STATUS   = 8'h05;
`ifdef SPI_MEM_FAST_READ_EN
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
`endif
  localparam logic [7:0] STATUS_BYTE = {6'b0, READ_ONLY != 0, 1'b0};

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_STATUS, ST_IGNORE
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            sclk_sync, mosi_sync, ce_sync;
  logic                  sclk_prev;
  logic                  sclk_s, mosi_s, ce_s;
  logic                  sclk_rise, sclk_fall;
  logic [7:0]            shreg, sh_in;
  logic [5:0]            bit_cnt;
  logic                  byte_done, addr_done;
  logic [DEPTH_LOG2-1:0] addr, addr_shift, addr_inc;
  logic [DEPTH_LOG2:0]   addr_ext;
  logic                  miso_q;
  logic                  op_write, op_fast, op_known;
  logic                  cmd_err_set;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem [0:(1<<DEPTH_LOG2)-1];

  // Bring the asynchronous SPI pins into the clk domain; ce resets to deselected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      ce_sync   <= 2'b11;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], bus.spi_clk};
      mosi_sync <= {mosi_sync[0], bus.spi_mosi};
      ce_sync   <= {ce_sync[0], bus.spi_ce_n};
      sclk_prev <= sclk_sync[1];
    end
  end

  assign sclk_s = sclk_sync[1];
  assign mosi_s = mosi_sync[1];
  assign ce_s   = ce_sync[1];

  // Edges only count while selected, so an edge landing with the ce rise is dropped
  assign sclk_rise = sclk_s & ~sclk_prev & ~ce_s;
  assign sclk_fall = ~sclk_s & sclk_prev & ~ce_s;

  assign sh_in      = {shreg[6:0], mosi_s};
  assign byte_done  = (bit_cnt == 6'd7);
  assign addr_done  = (bit_cnt == 6'(ADDR_BITS - 1));
  assign addr_ext   = {addr, mosi_s};
  assign addr_shift = addr_ext[DEPTH_LOG2-1:0];
  assign addr_inc   = addr + DEPTH_LOG2'(1);

  // Opcodes this build understands
  always_comb begin
    op_known = (sh_in == OP_READ) || (sh_in == OP_WRITE) || (sh_in == OP_STATUS);
`ifdef SPI_MEM_FAST_READ_EN
    op_known = op_known || (sh_in == OP_FAST_READ);
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: deselect overrides everything, otherwise advance on byte/field boundaries
  always_comb begin
    state_nxt = state;
    if (ce_s) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_CMD;
        ST_CMD: begin
          if (sclk_rise && byte_done) begin
            if (!op_known)                state_nxt = ST_IGNORE;
            else if (sh_in == OP_STATUS)  state_nxt = ST_STATUS;
            else if (sh_in == OP_WRITE)   state_nxt = (READ_ONLY != 0) ? ST_IGNORE : ST_ADDR;
            else                          state_nxt = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (sclk_rise && addr_done)
            state_nxt = op_write ? ST_WDATA : (op_fast ? ST_DUMMY : ST_RDATA);
        end
        ST_DUMMY: begin
          if (sclk_rise && byte_done) state_nxt = ST_RDATA;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Outputs and memory write port: SPI write byte or backdoor preload when idle
  always_comb begin
    busy        = ~ce_s;
    cmd_err_set = (state == ST_CMD) && sclk_rise && byte_done && !op_known;
    mem_we      = 1'b0;
    mem_waddr   = addr;
    mem_wdata   = sh_in;
    if ((state == ST_WDATA) && sclk_rise && byte_done && (READ_ONLY == 0)) begin
      mem_we = 1'b1;
    end else if (bus.ld_we && ce_s) begin
      mem_we    = 1'b1;
      mem_waddr = bus.ld_addr;
      mem_wdata = bus.ld_data;
    end
  end

  // Shift register, bit counter, address pointer and MISO driver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      addr     <= '0;
      miso_q   <= 1'b0;
      op_write <= 1'b0;
      op_fast  <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= cmd_err_set;
      case (state)
        ST_IDLE: begin
          shreg   <= '0;
          bit_cnt <= '0;
          addr    <= '0;
        end
        ST_CMD: begin
          if (sclk_rise) begin
            shreg   <= sh_in;
            bit_cnt <= bit_cnt + 6'd1;
            if (byte_done) begin
              bit_cnt  <= '0;
              op_write <= (sh_in == OP_WRITE);
`ifdef SPI_MEM_FAST_READ_EN
              op_fast  <= (sh_in == OP_FAST_READ);
`else
              op_fast  <= 1'b0;
`endif
              if (sh_in == OP_STATUS) shreg <= STATUS_BYTE;
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            addr    <= addr_shift;
            bit_cnt <= bit_cnt + 6'd1;
            if (addr_done) begin
              bit_cnt <= '0;
              shreg   <= mem[addr_shift];
            end
          end
        end
        ST_DUMMY: begin
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 6'd1;
            if (byte_done) begin
              bit_cnt <= '0;
              shreg   <= mem[addr];
            end
          end
        end
        ST_RDATA: begin
          if (sclk_fall) begin
            miso_q <= shreg[7];
            if (byte_done) begin
              bit_cnt <= '0;
              addr    <= addr_inc;
              shreg   <= mem[addr_inc];
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              shreg   <= {shreg[6:0], 1'b0};
            end
          end
        end
        ST_STATUS: begin
          if (sclk_fall) begin
            miso_q <= shreg[7];
            if (byte_done) begin
              bit_cnt <= '0;
              shreg   <= STATUS_BYTE;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              shreg   <= {shreg[6:0], 1'b0};
            end
          end
        end
        ST_WDATA: begin
          if (sclk_rise) begin
            shreg   <= sh_in;
            bit_cnt <= bit_cnt + 6'd1;
            if (byte_done) begin
              bit_cnt <= '0;
              addr    <= addr_inc;
            end
          end
        end
        default: begin
        end
      endcase
      if (ce_s) begin
        bit_cnt <= '0;
        miso_q  <= 1'b0;
      end
    end
  end

  // Byte array; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.spi_miso = miso_q;

endmodule
